mult_prec_sched: RTL
====================

MULT_PREC_SCHED -- requirements
Module: mult_prec_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 2, number of requester ports (2..4).
REQ-002 SHALL have parameter CNT_W, default 16, width of the completed-operation counter.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  N_REQ  per-requester operation valid.
REQ-006 SHALL have port req_ready  output  N_REQ  per-requester accept, one-hot or zero.
REQ-007 SHALL have port req_a  input  8*N_REQ  packed operand A per requester.
REQ-008 SHALL have port req_b  input  8*N_REQ  packed operand B per requester.
REQ-009 SHALL have port req_mode  input  2*N_REQ  precision: 00=1x8x8, 01=2x4x4, 10=4x2x2, 11=reserved.
REQ-010 SHALL have port req_sign  input  N_REQ  1=signed lanes, 0=unsigned lanes.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  downstream accept.
REQ-013 SHALL have port out_c  output  16  packed lane products, lane 0 in MSBs.
REQ-014 SHALL have port out_id  output  clog2(N_REQ)  requester index of result.
REQ-015 SHALL have port out_err  output  1  result came from reserved mode.
REQ-016 SHALL have port done_cnt  output  CNT_W  completed handshakes on output, saturating.

Function
REQ-017 SHALL arbitrate round-robin: search starts at index after last granted requester; grant pointer updates only on an accepted request.
REQ-018 SHALL assert req_ready[i] only for the granted i, and only when stage-1 register is empty or advancing this cycle.
REQ-019 SHALL capture a, b, mode, sign, id into stage-1 register on req_valid[i] & req_ready[i].
REQ-020 SHALL decode stage-1 mode to multiplier controls: 00->HALF_0, 01->HALF_1, 10->HALF_2 (one-hot), A_sign=B_sign=sign.
REQ-021 SHALL for mode 11 drive HALF_0, load out_c=0, out_err=1; no other effect.
REQ-022 SHALL register multiplier product into output register when stage 1 valid and (out_valid=0 or out_ready=1); latency accept-to-out_valid exactly 2 cycles.
REQ-023 SHALL sustain one operation per cycle with out_ready held high.
REQ-024 SHALL hold out_c, out_id, out_err, out_valid stable while out_valid=1 and out_ready=0; stage 1 then holds, req_ready drops to 0 once stage 1 full.
REQ-025 SHALL, on simultaneous output handshake and stage-1 advance, replace output register in same cycle with no bubble.
REQ-026 SHALL increment done_cnt on each out_valid & out_ready, saturating at all-ones.
REQ-027 SHALL keep lane products exact: 4x4 lanes 8 bits, 2x2 lanes 4 bits, sign-extended within lane when signed.
REQ-028 SHALL never drop or duplicate an accepted operation; results leave in acceptance order.

Reset
REQ-029 SHALL on rst_n=0 asynchronously clear stage-1 and output valid, out_c=0, out_id=0, out_err=0, done_cnt=0, req_ready=0, grant pointer to N_REQ-1 (first grant to requester 0).
REQ-030 SHALL discard in-flight operations on reset mid-operation; first acceptance allowed on first rising edge after rst_n deasserts.

Structure
REQ-031 SHALL place mode encodings (MODE_8, MODE_4, MODE_2, MODE_RSV) and lane widths in shared package mult_prec_pkg.
REQ-032 SHALL instantiate exactly one sub-module, multiplier_S_C2x2_F2_8bits_8bits_HighLevelDescribed_auto, combinational between stage-1 and output registers.
REQ-033 SHALL implement arbiter and pipeline control inline; no further sub-modules.

Verification
REQ-034 8x8 unsigned: a=200, b=100, sign=0, mode=00 -> out_c=16'h4E20 two cycles after accept, out_err=0.
REQ-035 8x8 signed a=8'hFD, b=8'h05 -> 16'hFFF1; 4x4 signed a=8'h3E, b=8'h25 -> 16'h06F6; 2x2 unsigned a=8'hFF, b=8'hFF -> 16'h9999.
REQ-036 Both requesters valid continuously, out_ready=1 -> grants and out_id alternate 0,1,0,1; one result per cycle.
REQ-037 out_ready=0 for 5 cycles with continuous requests -> two ops accepted then req_ready=0; output stable; all results delivered in order after release.
REQ-038 mode=11 -> out_c=0, out_err=1, done_cnt increments; rst_n pulsed low with both stages full -> out_valid=0 immediately, done_cnt=0, next grant to requester 0.

Source files
------------

// File: rtl/mult_prec_pkg.sv
// Shared definitions for the precision-configurable multiplier scheduler:
// mode encodings, lane operand widths and the per-lane product helper.
package mult_prec_pkg;

    typedef enum logic [1:0] {
        MODE_8   = 2'b00,
        MODE_4   = 2'b01,
        MODE_2   = 2'b10,
        MODE_RSV = 2'b11
    } prec_mode_e;

    localparam int OPND_W   = 8;
    localparam int PROD_W   = 16;
    localparam int LANE_W_8 = 8;
    localparam int LANE_W_4 = 4;
    localparam int LANE_W_2 = 2;

    // Exact product of the low w bits of x and y, each optionally two's
    // complement; the result is truncated to 2*w bits, which holds every
    // possible product and leaves it correctly sign-extended inside the lane.
    function automatic logic [15:0] lane_mul(
        input logic [7:0] x,
        input logic [7:0] y,
        input int         w,
        input logic       sx,
        input logic       sy
    );
        int xi;
        int yi;
        int p;
        int mask;
        mask = (32'sd1 <<< w) - 32'sd1;
        xi   = int'(x) & mask;
        yi   = int'(y) & mask;
        if (sx && (((xi >>> (w - 1)) & 32'sd1) != 32'sd0)) begin
            xi = xi - (32'sd1 <<< w);
        end else begin
            xi = xi;
        end
        if (sy && (((yi >>> (w - 1)) & 32'sd1) != 32'sd0)) begin
            yi = yi - (32'sd1 <<< w);
        end else begin
            yi = yi;
        end
        p = (xi * yi) & ((32'sd1 <<< (2 * w)) - 32'sd1);
        return 16'(p);
    endfunction

endpackage

// File: rtl/multiplier_S_C2x2_F2_8bits_8bits_HighLevelDescribed_auto.sv
// Combinational 8x8 multiplier that can split into two 4x4 or four 2x2
// lanes. Lane 0 uses the operand MSBs and lands in the product MSBs.
module multiplier_S_C2x2_F2_8bits_8bits_HighLevelDescribed_auto
    import mult_prec_pkg::*;
(
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic        half_0,
    input  logic        half_1,
    input  logic        half_2,
    input  logic        a_sign,
    input  logic        b_sign,
    output logic [15:0] c
);

    logic [15:0] p_full_s;
    logic [15:0] p_hi_s;
    logic [15:0] p_lo_s;
    logic [15:0] p_q_s;
    logic [15:0] c_s;

    // Select full-width, dual 4x4 or quad 2x2 product according to the one-hot controls.
    always_comb begin
        c_s      = 16'h0000;
        p_full_s = lane_mul(a, b, LANE_W_8, a_sign, b_sign);
        p_hi_s   = lane_mul({4'h0, a[7:4]}, {4'h0, b[7:4]}, LANE_W_4, a_sign, b_sign);
        p_lo_s   = lane_mul({4'h0, a[3:0]}, {4'h0, b[3:0]}, LANE_W_4, a_sign, b_sign);
        p_q_s    = 16'h0000;
        if (half_0) begin
            c_s = p_full_s;
        end else if (half_1) begin
            c_s = {p_hi_s[7:0], p_lo_s[7:0]};
        end else if (half_2) begin
            for (int l = 0; l < 4; l++) begin
                p_q_s = lane_mul({6'b000000, a[7-2*l -: 2]}, {6'b000000, b[7-2*l -: 2]},
                                 LANE_W_2, a_sign, b_sign);
                c_s[15-4*l -: 4] = p_q_s[3:0];
            end
        end else begin
            c_s = 16'h0000;
        end
    end

    assign c = c_s;

endmodule

// File: rtl/mult_prec_sched.sv
// Round-robin scheduler feeding a two-stage precision-configurable
// multiplier pipeline: stage-1 operand register, combinational multiplier,
// output register with valid/ready handshake and a saturating done counter.
module mult_prec_sched
    import mult_prec_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [8*N_REQ-1:0]         req_a,
    input  logic [8*N_REQ-1:0]         req_b,
    input  logic [2*N_REQ-1:0]         req_mode,
    input  logic [N_REQ-1:0]           req_sign,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_c,
    output logic [$clog2(N_REQ)-1:0]   out_id,
    output logic                       out_err,
    output logic [CNT_W-1:0]           done_cnt
);

    localparam int ID_W = $clog2(N_REQ);

    // arbiter
    logic [ID_W-1:0]  ptr_r;
    logic [N_REQ-1:0] grant_s;
    logic [ID_W-1:0]  grant_idx_s;
    logic             grant_any_s;

    // selected request payload
    logic [7:0]       sel_a_s;
    logic [7:0]       sel_b_s;
    prec_mode_e       sel_mode_s;
    logic             sel_sign_s;

    // stage 1
    logic             s1_valid_r;
    logic [7:0]       s1_a_r;
    logic [7:0]       s1_b_r;
    prec_mode_e       s1_mode_r;
    logic             s1_sign_r;
    logic [ID_W-1:0]  s1_id_r;

    // output stage
    logic             out_valid_r;
    logic [15:0]      out_c_r;
    logic [ID_W-1:0]  out_id_r;
    logic             out_err_r;
    logic [CNT_W-1:0] done_cnt_r;

    // pipeline control
    logic             advance_s;
    logic             s1_free_s;
    logic             accept_s;
    logic             out_fire_s;

    // multiplier controls
    logic             half_0_s;
    logic             half_1_s;
    logic             half_2_s;
    logic             rsv_s;
    logic [15:0]      mul_c_s;

    // Round-robin search: the requester closest after the last grant wins.
    always_comb begin
        int dist_v;
        int best_v;
        dist_v      = 0;
        best_v      = N_REQ;
        grant_idx_s = ptr_r;
        grant_any_s = 1'b0;
        grant_s     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            dist_v = (i + N_REQ - int'(ptr_r) - 1) % N_REQ;
            if (req_valid[i] && (dist_v < best_v)) begin
                best_v      = dist_v;
                grant_idx_s = ID_W'(i);
                grant_any_s = 1'b1;
            end else begin
                best_v = best_v;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            grant_s[i] = grant_any_s && (grant_idx_s == ID_W'(i));
        end
    end

    // Route the granted requester's operands toward stage 1.
    always_comb begin
        sel_a_s    = 8'h00;
        sel_b_s    = 8'h00;
        sel_mode_s = MODE_8;
        sel_sign_s = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_s[i]) begin
                sel_a_s    = req_a[8*i +: 8];
                sel_b_s    = req_b[8*i +: 8];
                sel_mode_s = prec_mode_e'(req_mode[2*i +: 2]);
                sel_sign_s = req_sign[i];
            end else begin
                sel_a_s = sel_a_s;
            end
        end
    end

    // Stage 1 moves forward whenever the output register is empty or draining;
    // ready is held low while reset is asserted.
    assign out_fire_s = out_valid_r & out_ready;
    assign advance_s  = s1_valid_r & (~out_valid_r | out_ready);
    assign s1_free_s  = ~s1_valid_r | advance_s;
    assign req_ready  = grant_s & {N_REQ{s1_free_s & rst_n}};
    assign accept_s   = |(req_valid & req_ready);

    // Remember the last accepted requester; the first grant after reset goes to requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= ID_W'(N_REQ - 1);
        end else if (accept_s) begin
            ptr_r <= grant_idx_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Stage-1 operand register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= 8'h00;
            s1_b_r     <= 8'h00;
            s1_mode_r  <= MODE_8;
            s1_sign_r  <= 1'b0;
            s1_id_r    <= '0;
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_a_r     <= sel_a_s;
            s1_b_r     <= sel_b_s;
            s1_mode_r  <= sel_mode_s;
            s1_sign_r  <= sel_sign_s;
            s1_id_r    <= grant_idx_s;
        end else if (advance_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Decode the stage-1 precision into one-hot multiplier controls; reserved runs as 8x8.
    always_comb begin
        half_0_s = 1'b0;
        half_1_s = 1'b0;
        half_2_s = 1'b0;
        rsv_s    = 1'b0;
        case (s1_mode_r)
            MODE_8:   half_0_s = 1'b1;
            MODE_4:   half_1_s = 1'b1;
            MODE_2:   half_2_s = 1'b1;
            MODE_RSV: begin
                half_0_s = 1'b1;
                rsv_s    = 1'b1;
            end
            default: begin
                half_0_s = 1'b1;
                rsv_s    = 1'b1;
            end
        endcase
    end

    multiplier_S_C2x2_F2_8bits_8bits_HighLevelDescribed_auto u_mul (
        .a      (s1_a_r),
        .b      (s1_b_r),
        .half_0 (half_0_s),
        .half_1 (half_1_s),
        .half_2 (half_2_s),
        .a_sign (s1_sign_r),
        .b_sign (s1_sign_r),
        .c      (mul_c_s)
    );

    // Output register: reload on advance (also covers drain-and-refill in one cycle), clear on drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_c_r     <= 16'h0000;
            out_id_r    <= '0;
            out_err_r   <= 1'b0;
        end else if (advance_s) begin
            out_valid_r <= 1'b1;
            out_c_r     <= rsv_s ? 16'h0000 : mul_c_s;
            out_id_r    <= s1_id_r;
            out_err_r   <= rsv_s;
        end else if (out_fire_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Count output handshakes, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt_r <= '0;
        end else if (out_fire_s && !(&done_cnt_r)) begin
            done_cnt_r <= done_cnt_r + CNT_W'(1);
        end else begin
            done_cnt_r <= done_cnt_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_c     = out_c_r;
    assign out_id    = out_id_r;
    assign out_err   = out_err_r;
    assign done_cnt  = done_cnt_r;

endmodule
